// File: rtl/systolic_skew_feeder_if.sv
// Operand/handshake bundle between a job controller and the systolic skew feeder.
// The feeder side uses the slave modport; the controller side uses master.
interface systolic_skew_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8,
  parameter int K_WIDTH    = 8
);
  localparam int SW = $clog2(N + 1);

  logic                    start;
  logic [SW-1:0]           size;
  logic [K_WIDTH-1:0]      k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] a_vec;
  logic [N*DATA_WIDTH-1:0] b_vec;
  logic [N*DATA_WIDTH-1:0] a_out;
  logic [N*DATA_WIDTH-1:0] b_out;
  logic                    pe_clear;
  logic                    busy;
  logic                    done;
  logic [15:0]             bubble_cnt;

  modport master (
    output start, size, k_len, in_valid, a_vec, b_vec,
    input  in_ready, a_out, b_out, pe_clear, busy, done, bubble_cnt
  );

  modport slave (
    input  start, size, k_len, in_valid, a_vec, b_vec,
    output in_ready, a_out, b_out, pe_clear, busy, done, bubble_cnt
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew sequencer feeding A rows / B columns into an N x N PE array.
// Lane i is delayed i+1 cycles; lanes at or above the active size carry zeros.
// Optional macro FEEDER_PERF_CNT_EN builds the saturating bubble counter;
// without it bubble_cnt is tied to zero.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8,
  parameter int K_WIDTH    = 8,
  parameter int PE_LAT     = 1
) (
  input logic                  clk,
  input logic                  reset,
  systolic_skew_feeder_if.slave bus
);
  localparam int SW  = $clog2(N + 1);
  localparam int DCW = $clog2(2 * N + PE_LAT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [SW-1:0]      size_reg, size_next;
  logic [K_WIDTH-1:0] k_len_reg, k_len_next;
  logic [K_WIDTH-1:0] accepted_reg, accepted_next;
  logic [DCW-1:0]     drain_reg, drain_next;
  logic [DCW-1:0]     drain_last;
  logic [SW-1:0]      size_eff;
  logic               accept;
  logic               in_ready;
  logic               pe_clear;
  logic               done;

  // A requested size of 0 or beyond the array means "use the whole array".
  assign size_eff = ((bus.size == '0) || (bus.size > SW'(N))) ? SW'(N) : bus.size;

  // Last drain index: the final product needs 2*(size-1)+1+PE_LAT cycles to land.
  assign drain_last = DCW'({size_reg, 1'b0}) + DCW'(PE_LAT) - DCW'(2);

  // State and job-parameter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      size_reg     <= '0;
      k_len_reg    <= '0;
      accepted_reg <= '0;
      drain_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      size_reg     <= size_next;
      k_len_reg    <= k_len_next;
      accepted_reg <= accepted_next;
      drain_reg    <= drain_next;
    end
  end

  // Next-state logic and control outputs.
  always_comb begin
    state_next    = state_reg;
    size_next     = size_reg;
    k_len_next    = k_len_reg;
    accepted_next = accepted_reg;
    drain_next    = drain_reg;
    accept        = 1'b0;
    in_ready      = 1'b0;
    pe_clear      = 1'b0;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          size_next  = size_eff;
          k_len_next = bus.k_len;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        pe_clear      = 1'b1;
        accepted_next = '0;
        drain_next    = '0;
        state_next    = (k_len_reg == '0) ? DRAIN : FEED;
      end
      FEED: begin
        in_ready = (accepted_reg < k_len_reg);
        accept   = bus.in_valid && in_ready;
        if (accept) begin
          accepted_next = accepted_reg + 1'b1;
          if (accepted_reg == k_len_reg - 1'b1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        drain_next = drain_reg + 1'b1;
        if (drain_reg == drain_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.pe_clear = pe_clear;
  assign bus.done     = done;
  assign bus.busy     = (state_reg != IDLE);

  // Skew lanes: every cycle shifts; non-accept cycles push a zero bubble.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_sr [gi+1];
      logic [DATA_WIDTH-1:0] b_sr [gi+1];
      logic                  lane_on;

      assign lane_on = accept && (SW'(gi) < size_reg);

      // Shift register of depth gi+1 for this lane's A and B operands.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j <= gi; j++) begin
            a_sr[j] <= '0;
            b_sr[j] <= '0;
          end
        end else begin
          a_sr[0] <= lane_on ? bus.a_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          b_sr[0] <= lane_on ? bus.b_vec[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
          for (int j = 1; j <= gi; j++) begin
            a_sr[j] <= a_sr[j-1];
            b_sr[j] <= b_sr[j-1];
          end
        end
      end

      assign bus.a_out[gi*DATA_WIDTH +: DATA_WIDTH] = a_sr[gi];
      assign bus.b_out[gi*DATA_WIDTH +: DATA_WIDTH] = b_sr[gi];
    end
  endgenerate

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] bubble_reg;

  // Saturating count of FEED cycles without an accept; cleared when a job starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      bubble_reg <= '0;
    end else if (state_reg == FEED && !accept && bubble_reg != 16'hFFFF) begin
      bubble_reg <= bubble_reg + 16'd1;
    end
  end

  assign bus.bubble_cnt = bubble_reg;
`else
  assign bus.bubble_cnt = '0;
`endif
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Parametrised operand sequencer for the next-generation N x N FP16 systolic PE array.
- Accepts unskewed A-row and B-column vectors, one of each per step, and applies a diagonal skew: lane i is delayed i+1 cycles.
- Zeroes the lanes above the active size, clears the PE accumulators before a job, and signals done once the last product has landed in PE(size-1,size-1).
- Replaces the per-lane hand skewing that benches currently do by hand.

Parameters:
- DATA_WIDTH, 16, operand width (FP16 bit pattern; zero is all-zeros).
- N, 8, maximum array dimension and lane count.
- K_WIDTH, 8, width of the k_len step counter.
- PE_LAT, 1, PE multiply-accumulate latency in cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- size  in  $clog2(N+1)  active array dimension; 0 or >N is treated as N.
- k_len  in  K_WIDTH  number of operand vectors in the job.
- in_valid  in  1  a_vec/b_vec hold a valid step.
- in_ready  out  1  feeder accepts a step this cycle.
- a_vec  in  N*DATA_WIDTH  A lanes; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_vec  in  N*DATA_WIDTH  B lanes, same packing.
- a_out  out  N*DATA_WIDTH  skewed A lanes to the array row inputs.
- b_out  out  N*DATA_WIDTH  skewed B lanes to the array column inputs.
- pe_clear  out  1  one-cycle accumulator clear.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle job-complete pulse.
- bubble_cnt  out  16  count of bubble steps in the current job.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; all skew registers and counters clear.
  - every output is 0 the cycle after reset is sampled high, including in the middle of a job.
- States:
  - IDLE: start=1 latches size and k_len, then goes to CLEAR.
  - CLEAR: pe_clear=1 for exactly one cycle. Go to FEED, or to DRAIN if k_len=0.
  - FEED: in_ready = (accepted < k_len). Each cycle:
    - in_valid & in_ready: push the input vector into the skew stage, accepted++.
    - otherwise: push an all-zero bubble vector and increment the bubble count. Bubbles contribute zero products and preserve diagonal alignment.
    - On the last accept, go to DRAIN on the same edge.
  - DRAIN: push zero vectors for D = 2*(size-1) + 1 + PE_LAT cycles, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Skew stage:
  - Lane i is a shift register of depth i+1.
  - a_out lane i = A lane i value pushed i+1 cycles earlier; b_out likewise.
  - Lanes with index >= size are forced to zero at push, whatever is on the inputs.
- start while busy is ignored; latched size and k_len stay stable for the whole job.
- in_ready=0 in every state except FEED; in_valid outside FEED is ignored.
- Back-to-back jobs: start asserted during the DONE cycle is ignored. start is accepted in IDLE, at the earliest the cycle after done.

Optional Feature:
- FEEDER_PERF_CNT_EN defined:
  - bubble_cnt counts FEED cycles without an accept and saturates at 16'hFFFF.
  - Cleared on CLEAR entry; holds its value after DONE until the next job starts.
- Not defined: bubble_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset: assert reset for 2 cycles, with garbage on the inputs -> all outputs 0, busy=0, in_ready=0.
- Full 5x5 job (N=5, PE_LAT=1, size=5, k_len=5):
  - Stimulus: start sampled at edge 0; A = 3C00,4000,4200,4400,4500 on all lanes; B = C000; in_valid held high.
  - Required: pe_clear in cycle 1; accepts in cycles 2-6.
  - Required: a_out lane0 = 3C00 in cycle 3; lane4 = 3C00 in cycle 7.
  - Required: DRAIN in cycles 7-16, done in cycle 17, busy=0 in cycle 18.
- Bubbles: same job with in_valid=0 in cycles 3-4 -> zeros pushed on those steps, done in cycle 19, bubble_cnt=2 (0 when FEEDER_PERF_CNT_EN is not defined).
- Reduced size: size=3, k_len=4, nonzero inputs on all 5 lanes -> lanes 3-4 of a_out/b_out stay 0 throughout; accepts in cycles 2-5, DRAIN in cycles 6-11, done in cycle 12.
- k_len=0 with size=5 -> CLEAR in cycle 1, in_ready never asserts, DRAIN in cycles 2-11, done in cycle 12.
- Interference:
  - start pulsed in cycle 4 of a running job -> no effect on timing.
  - reset in cycle 4 -> cycle 5 shows busy=0, in_ready=0, all skew outputs 0; a new start then runs a clean job.
